// File: rtl/pattern_writer.sv
// Framebuffer test-pattern generator: writes one RGB565 frame, one pixel per SDRAM write.
// Optional `PATTERN_BORDER_EN forces a white one-pixel border over every pattern.
module pattern_writer #(
  parameter int H_RES     = 320,
  parameter int V_RES     = 240,
  parameter int X_W       = 9,
  parameter int Y_W       = 15,
  parameter int BARS      = 4,
  parameter int CELL_LOG2 = 4
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               iStart,
  input  logic [1:0]         iMode,
  input  logic [15:0]        iColor,
  output logic               oCall,
  input  logic               iDone,
  output logic [X_W+Y_W-1:0] oAddr,
  output logic [15:0]        oData,
  output logic               oBusy,
  output logic               oFrameDone,
  output logic [1:0]         dbg_state
);

  localparam int BAR_W = H_RES / BARS;
  localparam logic [X_W-1:0] X_LAST   = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_RES - 1);
  localparam logic [X_W-1:0] BAR_LAST = X_W'(BAR_W - 1);
  localparam logic [2:0]     IDX_LAST = 3'(BARS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ADV   = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t         state, state_next;
  logic [X_W-1:0] x, bar_cnt;
  logic [Y_W-1:0] y;
  logic [2:0]     bar_idx;
  logic [1:0]     mode_q;
  logic [15:0]    color_q;
  logic           at_last;
  logic           accept;
  logic [15:0]    pix;

  // Write handshake: oCall is the valid, iDone the one-cycle ready/ack. A write
  // completes only on an edge where both are high; address and data hold
  // steady while oCall is up, and iDone seen with oCall low is ignored.
  assign accept  = oCall && iDone;
  assign at_last = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (iStart) state_next = S_WRITE;
      S_WRITE: if (accept) state_next = S_ADV;
      S_ADV:   state_next = at_last ? S_FIN : S_WRITE;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      x       <= '0;
      y       <= '0;
      bar_idx <= '0;
      bar_cnt <= '0;
      mode_q  <= '0;
      color_q <= '0;
      oCall   <= 1'b0;
    end else begin
      // oCall rises one cycle after entering WRITE, so a new request never
      // overlaps the cycle in which the previous ack was seen.
      oCall <= (state == S_WRITE) && !accept;
      case (state)
        S_IDLE: begin
          if (iStart) begin
            mode_q  <= iMode;
            color_q <= iColor;
            x       <= '0;
            y       <= '0;
            bar_idx <= '0;
            bar_cnt <= '0;
          end
        end
        S_ADV: begin
          if (!at_last) begin
            if (x == X_LAST) begin
              x       <= '0;
              y       <= y + 1'b1;
              bar_idx <= '0;
              bar_cnt <= '0;
            end else begin
              x <= x + 1'b1;
              if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                // Saturating index hands any remainder pixels to the last bar.
                if (bar_idx != IDX_LAST) bar_idx <= bar_idx + 1'b1;
              end else begin
                bar_cnt <= bar_cnt + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pix = '0;
    case (mode_q)
      2'd0: begin
        case (bar_idx)
          3'd0:    pix = 16'hF800;
          3'd1:    pix = 16'hF81F;
          3'd2:    pix = 16'h001F;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hFFE0;
          3'd5:    pix = 16'h07FF;
          3'd6:    pix = 16'hFFFF;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = (1'(x >> CELL_LOG2) ^ 1'(y >> CELL_LOG2)) ? 16'hFFFF : 16'h0000;
      2'd2:    pix = {5'(x >> 3), 6'(x >> 2), 5'(x >> 3)};
      default: pix = color_q;
    endcase
`ifdef PATTERN_BORDER_EN
    if ((x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST)) pix = 16'hFFFF;
`endif
  end

  assign oData      = (state == S_IDLE) ? 16'h0000 : pix;
  assign oAddr      = {y, x};
  assign oBusy      = (state == S_WRITE) || (state == S_ADV);
  assign oFrameDone = (state == S_FIN);
  assign dbg_state  = state;

endmodule

// File: tb/tb_pattern_writer.sv
// Bench for pattern_writer: random-latency write port, queue scoreboard fed by a
// pixel-rule reference model, reset-abort and restart scenario.
module tb_pattern_writer;

  localparam int H_RES     = 260;
  localparam int V_RES     = 10;
  localparam int X_W       = 9;
  localparam int Y_W       = 15;
  localparam int BARS      = 3;
  localparam int CELL_LOG2 = 3;
  localparam int AW        = X_W + Y_W;
  localparam int BAR_W     = H_RES / BARS;
  localparam int CELL      = 1 << CELL_LOG2;
  localparam int NPIX      = H_RES * V_RES;
  localparam logic [15:0] PALETTE [8] = '{16'hF800, 16'hF81F, 16'h001F, 16'h07E0,
                                          16'hFFE0, 16'h07FF, 16'hFFFF, 16'h0000};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [15:0]   color = 16'h0000;
  logic          done = 1'b0;
  logic          call, busy, frame_done;
  logic [AW-1:0] addr;
  logic [15:0]   data;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int writes = 0;
  int frames = 0;
  int lat = 0;

  logic [AW+15:0] exp_q[$];
  logic [15:0]    obs [int];

  pattern_writer #(
    .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W),
    .BARS(BARS), .CELL_LOG2(CELL_LOG2)
  ) dut (
    .CLOCK(clk), .RESET(rst), .iStart(start), .iMode(mode), .iColor(color),
    .oCall(call), .iDone(done), .oAddr(addr), .oData(data),
    .oBusy(busy), .oFrameDone(frame_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int akey(input int x, input int y);
    return y * (1 << X_W) + x;
  endfunction

  // Reference pixel rule, computed directly from the pattern definitions.
  function automatic logic [15:0] model_pixel(input logic [1:0] m, input logic [15:0] c,
                                              input int x, input int y);
    int idx, g, r, gg;
`ifdef PATTERN_BORDER_EN
    if (x == 0 || x == H_RES - 1 || y == 0 || y == V_RES - 1) return 16'hFFFF;
`endif
    case (m)
      2'd0: begin
        idx = x / BAR_W;
        if (idx > BARS - 1) idx = BARS - 1;
        return PALETTE[idx];
      end
      2'd1: return (((x / CELL) + (y / CELL)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      2'd2: begin
        g  = x % 256;
        r  = g / 8;
        gg = g / 4;
        return 16'(r * 2048 + gg * 32 + r);
      end
      default: return c;
    endcase
  endfunction

  // Write-port responder and scoreboard; also injects stray acks while oCall is low.
  always @(negedge clk) begin
    if (rst) begin
      done = 1'b0;
    end else if (done) begin
      done = 1'b0;
    end else if (call) begin
      if (lat == 0) begin
        done = 1'b1;
        lat = $urandom_range(0, 1);
        writes++;
        obs[akey(int'(addr) % (1 << X_W), int'(addr) / (1 << X_W))] = data;
        check("busy_during_call", 40'(busy), 40'd1);
        if (exp_q.size() == 0) check("extra_write", {16'h0, addr}, 40'hFFFFFFFFFF);
        else check("pixel", {addr, data}, exp_q.pop_front());
      end else begin
        lat--;
      end
    end else if ($urandom_range(0, 5) == 0) begin
      done = 1'b1;
    end
    if (frame_done) begin
      frames++;
      check("busy_at_done", 40'(busy), 40'd0);
    end
  end

  task automatic load_expect(input logic [1:0] m, input logic [15:0] c);
    logic [AW-1:0] a;
    exp_q.delete();
    obs.delete();
    for (int y = 0; y < V_RES; y++) begin
      for (int x = 0; x < H_RES; x++) begin
        a = AW'(akey(x, y));
        exp_q.push_back({a, model_pixel(m, c, x, y)});
      end
    end
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [15:0] c);
    @(negedge clk);
    mode  = m;
    color = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [15:0] c, input bit disturb);
    int  f0, w0;
    bit  disturbed;
    f0 = frames;
    w0 = writes;
    disturbed = 1'b0;
    load_expect(m, c);
    pulse_start(m, c);
    @(negedge clk);
    check("start_call", 40'(call), 40'd1);
    check("start_busy", 40'(busy), 40'd1);
    check("start_addr", 40'(addr), 40'd0);
    for (int i = 0; i < NPIX * 6 && frames == f0; i++) begin
      @(negedge clk);
      if (disturb && !disturbed && (writes - w0) >= 500) begin
        color = ~c;
        mode  = m + 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        disturbed = 1'b1;
      end
    end
    if (frames == f0) check("frame_timeout", 40'd0, 40'd1);
    check("write_count", 40'(writes - w0), 40'(NPIX));
    check("queue_empty", 40'(exp_q.size()), 40'd0);
    repeat (12) @(negedge clk);
    check("frame_done_count", 40'(frames - f0), 40'd1);
    check("idle_busy", 40'(busy), 40'd0);
    check("idle_call", 40'(call), 40'd0);
    check("idle_data", 40'(data), 40'd0);
  endtask

  initial begin
    int w0, f0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_call", 40'(call), 40'd0);
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_frame_done", 40'(frame_done), 40'd0);
    check("rst_addr", 40'(addr), 40'd0);
    check("rst_data", 40'(data), 40'd0);
    check("rst_state", 40'(dbg_state), 40'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(2'd0, 16'h0000, 1'b0);
    check("bar_85_3", 40'(obs[akey(85, 3)]), 40'hF800);
    check("bar_86_3", 40'(obs[akey(86, 3)]), 40'hF81F);
    check("bar_171_3", 40'(obs[akey(171, 3)]), 40'hF81F);
    check("bar_172_3", 40'(obs[akey(172, 3)]), 40'h001F);
    check("bar_258_3", 40'(obs[akey(258, 3)]), 40'h001F);
`ifdef PATTERN_BORDER_EN
    check("border_0_5", 40'(obs[akey(0, 5)]), 40'hFFFF);
    check("border_5_0", 40'(obs[akey(5, 0)]), 40'hFFFF);
`else
    check("bar_0_5", 40'(obs[akey(0, 5)]), 40'hF800);
    check("bar_259_9", 40'(obs[akey(259, 9)]), 40'h001F);
`endif

    run_frame(2'd1, 16'h0000, 1'b0);
    check("chk_7_1", 40'(obs[akey(7, 1)]), 40'h0000);
    check("chk_8_1", 40'(obs[akey(8, 1)]), 40'hFFFF);
    check("chk_8_8", 40'(obs[akey(8, 8)]), 40'h0000);
    check("chk_16_8", 40'(obs[akey(16, 8)]), 40'hFFFF);

    run_frame(2'd2, 16'h0000, 1'b0);
    check("ramp_8", 40'(obs[akey(8, 1)]), 40'h0841);
    check("ramp_128", 40'(obs[akey(128, 1)]), 40'h8410);
    check("ramp_255", 40'(obs[akey(255, 1)]), 40'hFFFF);
    check("ramp_256", 40'(obs[akey(256, 1)]), 40'h0000);

    run_frame(2'd3, 16'h1234, 1'b1);
    check("solid_mid", 40'(obs[akey(130, 4)]), 40'h1234);

    // Abort a frame with reset after 1000 pixels, then restart from scratch.
    w0 = writes;
    f0 = frames;
    load_expect(2'd0, 16'h0000);
    pulse_start(2'd0, 16'h0000);
    for (int i = 0; i < 20000 && (writes - w0) < 1000; i++) @(negedge clk);
    check("reach_1000", 40'((writes - w0) >= 1000), 40'd1);
    rst = 1'b1;
    #1;
    check("abort_call", 40'(call), 40'd0);
    check("abort_busy", 40'(busy), 40'd0);
    check("abort_state", 40'(dbg_state), 40'd0);
    check("abort_addr", 40'(addr), 40'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", 40'(frames - f0), 40'd0);
    check("abort_idle_call", 40'(call), 40'd0);

    run_frame(2'd0, 16'h0000, 1'b0);
    check("restart_bar_86_3", 40'(obs[akey(86, 3)]), 40'hF81F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_writer.md
# pattern_writer

Parametrised framebuffer test-pattern generator. It writes one full frame of RGB565 pixels into SDRAM, one pixel per write, through the `iCall`/`oDone` write port of the SDRAM/VGA graphic submodule. It supports four selectable patterns (colour bars, checkerboard, grey ramp, solid colour), a configurable resolution and bar count, and start/finished handshaking. It sits in the `CLOCK_MAIN` domain between the top-level controller and the SDRAM write port.

## Interface
- `H_RES`, 320: pixels per line (2..2^X_W).
- `V_RES`, 240: lines per frame (2..2^Y_W).
- `X_W`, 9: X counter width; low field of the address.
- `Y_W`, 15: Y counter width; high field of the address. `X_W+Y_W` = 24.
- `BARS`, 4: colour-bar count (1..8). Bar width `BAR_W = H_RES/BARS`.
- `CELL_LOG2`, 4: checkerboard cell size is 2^CELL_LOG2 pixels.
- `CLOCK`, in, 1: main clock; all logic is on the rising edge.
- `RESET`, in, 1: asynchronous, active-high reset.
- `iStart`, in, 1: single-cycle start request; ignored while busy.
- `iMode`, in, 2: 0 = bars, 1 = checker, 2 = ramp, 3 = solid. Sampled on the accepted start.
- `iColor`, in, 16: solid colour (RGB565). Sampled on the accepted start.
- `oCall`, out, 1: write request to the SDRAM port ([1] Write bit of the port's `iCall`).
- `iDone`, in, 1: write acknowledge from the port (`oDone[1]`). A one-cycle pulse.
- `oAddr`, out, 24: `{Y, X}`.
- `oData`, out, 16: pixel in RGB565 `{R5, G6, B5}`.
- `oBusy`, out, 1: high from the accepted start until frame completion.
- `oFrameDone`, out, 1: one-cycle pulse after the last pixel is acknowledged.

## Operation
- States: IDLE, WRITE, ADV, FIN.
  - IDLE: on `iStart`, latch `iMode`/`iColor`, clear X, Y, bar index and bar-pixel count, then go to WRITE.
  - WRITE: hold `oCall`=1 with `oAddr`/`oData` stable. On `iDone`=1, drop `oCall` and go to ADV.
  - ADV: advance counters.
    - If X = H_RES-1 and Y = V_RES-1, go to FIN.
    - Otherwise step X; on wrap, X←0 and Y←Y+1. Then go to WRITE.
  - FIN: pulse `oFrameDone`, drop `oBusy`, return to IDLE.
- Bar index comes from a counter, not a divider.
  - The bar-pixel counter counts 0..BAR_W-1. On its wrap, the bar index increments, saturating at BARS-1, so remainder pixels take the last bar.
  - Both counters clear on each new line.
- Bar palette, by index 0..7: F800 red, F81F magenta, 001F blue, 07E0 green, FFE0 yellow, 07FF cyan, FFFF white, 0000 black.
- Checker: FFFF if `X[CELL_LOG2]^Y[CELL_LOG2]`, else 0000.
- Ramp: `{X[7:3], X[7:2], X[7:3]}`. It is a grey ramp that repeats every 256 pixels. X bits above the width read as 0.
- Solid: the latched colour.
- `oData` is combinational from the latched mode and the counters, valid whenever `oCall`=1.

## Timing
- Reset values:
  - State IDLE.
  - `oCall`, `oBusy`, `oFrameDone` = 0.
  - `oAddr` = 0, `oData` = 0 (`oData` forced to 0 in IDLE).
  - Latched mode = 0, latched colour = 0.
- Start sequence: `iStart` at edge n → `oCall`=1 and `oBusy`=1 after edge n+1, with `oAddr`=0.
- Per pixel: `iDone` sampled at edge k → `oCall`=0 after k; ADV at k+1; `oCall`=1 with the next address after k+2. Minimum is 3 cycles per pixel plus port latency.
- `oCall` is never reasserted in the cycle in which `iDone` is seen. An `iDone` arriving while `oCall`=0 is ignored.
- Frame end: `oFrameDone` is high for exactly one cycle, the cycle after the ADV of the last pixel. `oBusy` falls in the same cycle.
- `iStart` during `oBusy` is ignored. `iStart` in the FIN cycle is ignored.
- `RESET` mid-frame returns immediately to reset values. No partial write completes, and the frame is not resumed.

## Configuration
- `PATTERN_BORDER_EN`
  - Defined: pixels with X=0, X=H_RES-1, Y=0 or Y=V_RES-1 are written FFFF in every mode, overriding the pattern.
  - Undefined: no border logic; the pattern covers the full frame.

## Test plan
- Bars, defaults, port acks 2 cycles after `oCall`:
  - pixel (79,0)=F800, (80,0)=F81F, (239,5)=001F, (319,239)=07E0.
  - Exactly 76800 writes, one `oFrameDone`.
- `BARS`=3, `H_RES`=10:
  - BAR_W=3; X 0-2 = F800, 3-5 = F81F, 6-9 = 001F (remainder saturates).
- Checker, `CELL_LOG2`=4:
  - (15,0)=0000, (16,0)=FFFF, (16,16)=0000.
- Ramp:
  - X=0 → 0000, X=255 → FFFF, X=256 → 0000.
- Solid with `iColor`=1234:
  - All pixels 1234.
  - `iColor` changed and `iStart` pulsed mid-frame: no effect, frame completes unchanged.
- `RESET` pulse at pixel 1000: `oCall`/`oBusy` are 0 asynchronously, and no `oFrameDone` occurs.
  - A new `iStart` writes again from address 0.
  - With `PATTERN_BORDER_EN`: (0,5) and (5,0) are FFFF in bars mode.
